ex1_a_mux: RTL and testbench

//  - Five-input selector: routes one of u, v, w, x, y to output m using the 3-bit select {s2,s1,s0}.
//  - m is purely combinational, with zero latency.
//  - A registered copy (m_q) and the registered select (sel_q) give clocked consumers a glitch-free view.
//  - Leaf datapath block; it has no handshake and no internal state other than the output registers.

---
 rtl/ex1_a_pkg.sv | 11 +
 rtl/ex1_a_mux_mux5_comb.sv | 33 +++
 rtl/ex1_a_mux.sv | 47 ++++
 tb/tb_ex1_a_mux.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/ex1_a_pkg.sv
// Shared select encodings for the ex1_a five-input selector.
// s2 dominates: any select with the MSB set routes y.
package ex1_a_pkg;

   localparam logic [2:0] SEL_U     = 3'b000;
   localparam logic [2:0] SEL_V     = 3'b001;
   localparam logic [2:0] SEL_W     = 3'b010;
   localparam logic [2:0] SEL_X     = 3'b011;
   localparam logic       SEL_Y_MSB = 1'b1;

endpackage

// File: rtl/ex1_a_mux_mux5_comb.sv
// Pure combinational WIDTH-bit 5:1 selector (u/v/w/x by low select bits, y when s2 set).
module mux5_comb
   import ex1_a_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic [2:0]       sel,
   input  logic [WIDTH-1:0] u,
   input  logic [WIDTH-1:0] v,
   input  logic [WIDTH-1:0] w,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] m
);

   // Explicit ==1 / ==0 tests keep an unknown s2 from falling into the u..x decode,
   // while a known s2=1 still yields y whatever s1/s0 are.
   always_comb begin
      m = 'x;
      if (sel[2] == SEL_Y_MSB) begin
         m = y;
      end else if (sel[2] == ~SEL_Y_MSB) begin
         case (sel)
            SEL_U:   m = u;
            SEL_V:   m = v;
            SEL_W:   m = w;
            SEL_X:   m = x;
            default: m = 'x;
         endcase
      end
   end

endmodule

// File: rtl/ex1_a_mux.sv
// Five-input selector with combinational output m plus registered m_q/sel_q
// for clocked consumers; async active-low reset clears only the registers.
module ex1_a_mux
   import ex1_a_pkg::*;
#(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             s2,
   input  logic             s1,
   input  logic             s0,
   input  logic [WIDTH-1:0] u,
   input  logic [WIDTH-1:0] v,
   input  logic [WIDTH-1:0] w,
   input  logic [WIDTH-1:0] x,
   input  logic [WIDTH-1:0] y,
   output logic [WIDTH-1:0] m,
   output logic [WIDTH-1:0] m_q,
   output logic [2:0]       sel_q
);

   logic [2:0] sel;

   assign sel = {s2, s1, s0};

   mux5_comb #(.WIDTH(WIDTH)) u_mux (
      .sel (sel),
      .u   (u),
      .v   (v),
      .w   (w),
      .x   (x),
      .y   (y),
      .m   (m)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_q   <= '0;
         sel_q <= SEL_U;
      end else begin
         m_q   <= m;
         sel_q <= sel;
      end
   end

endmodule

// File: tb/tb_ex1_a_mux.sv
// Bench for ex1_a_mux: WIDTH=1 and WIDTH=8 instances share clock, reset and select;
// expected values go through scoreboard queues and are popped when the DUT output is sampled.
module tb_ex1_a_mux;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       s2, s1, s0;
   logic       u1, v1, w1, x1, y1, m1, mq1;
   logic [2:0] selq1, selq8;
   logic [7:0] u8, v8, w8, x8, y8, m8, mq8;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [2:0] sel;
      logic [4:0] d;     // {u,v,w,x,y}
      logic       exp;
   } vec_t;

   typedef struct {
      logic [7:0] m1;
      logic [7:0] m8;
      logic [2:0] sel;
   } sb_t;

   vec_t vecs[12];
   sb_t  comb_q[$];
   sb_t  reg_q[$];

   always #10 clk = ~clk;

   ex1_a_mux #(.WIDTH(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .s2(s2), .s1(s1), .s0(s0),
      .u(u1), .v(v1), .w(w1), .x(x1), .y(y1),
      .m(m1), .m_q(mq1), .sel_q(selq1)
   );

   ex1_a_mux #(.WIDTH(8)) dut8 (
      .clk(clk), .rst_n(rst_n), .s2(s2), .s1(s1), .s0(s0),
      .u(u8), .v(v8), .w(w8), .x(x8), .y(y8),
      .m(m8), .m_q(mq8), .sel_q(selq8)
   );

   function automatic logic [7:0] ref_mux(input logic [2:0] s, input logic [7:0] a, b, c, d, e);
      if (s[2]) return e;
      case (s[1:0])
         2'd0:    return a;
         2'd1:    return b;
         2'd2:    return c;
         default: return d;
      endcase
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step(input logic [2:0] sel, input logic [4:0] d, input logic e1,
                       input logic [7:0] a, b, c, dd, ee, input string tag);
      sb_t t;
      @(negedge clk);
      {s2, s1, s0} = sel;
      {u1, v1, w1, x1, y1} = d;
      u8 = a; v8 = b; w8 = c; x8 = dd; y8 = ee;
      t.m1  = {7'b0, e1};
      t.m8  = ref_mux(sel, a, b, c, dd, ee);
      t.sel = sel;
      comb_q.push_back(t);
      reg_q.push_back(t);
      #5;
      t = comb_q.pop_front();
      check({tag, " m"}, {7'b0, m1}, t.m1);
      check({tag, " m8"}, m8, t.m8);
      @(posedge clk);
      #1;
      t = reg_q.pop_front();
      check({tag, " m_q"}, {7'b0, mq1}, t.m1);
      check({tag, " sel_q"}, {5'b0, selq1}, {5'b0, t.sel});
      check({tag, " m_q8"}, mq8, t.m8);
   endtask

   initial begin
      logic [2:0] rs;
      logic [7:0] ra, rb, rc, rd, re, rm;

      vecs[0]  = '{3'b000, 5'b00000, 1'b0};
      vecs[1]  = '{3'b000, 5'b10000, 1'b1};
      vecs[2]  = '{3'b001, 5'b01000, 1'b1};
      vecs[3]  = '{3'b001, 5'b10111, 1'b0};
      vecs[4]  = '{3'b010, 5'b00010, 1'b0};
      vecs[5]  = '{3'b010, 5'b00100, 1'b1};
      vecs[6]  = '{3'b011, 5'b00010, 1'b1};
      vecs[7]  = '{3'b011, 5'b11101, 1'b0};
      vecs[8]  = '{3'b100, 5'b00001, 1'b1};
      vecs[9]  = '{3'b101, 5'b00101, 1'b1};
      vecs[10] = '{3'b110, 5'b00110, 1'b0};
      vecs[11] = '{3'b111, 5'b11110, 1'b0};

      rst_n = 1'b0;
      {s2, s1, s0} = 3'b011;
      {u1, v1, w1, x1, y1} = 5'b00010;
      {u8, v8, w8, x8, y8} = '0;
      #3;
      check("reset m_q", {7'b0, mq1}, 8'h00);
      check("reset sel_q", {5'b0, selq1}, 8'h00);
      check("reset m_q8", mq8, 8'h00);
      check("m during reset", {7'b0, m1}, 8'h01);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i])
         step(vecs[i].sel, vecs[i].d, vecs[i].exp, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00,
              $sformatf("vec%0d", i));

      for (int i = 0; i < 16; i++) begin
         rs = 3'($urandom);
         ra = 8'($urandom); rb = 8'($urandom); rc = 8'($urandom);
         rd = 8'($urandom); re = 8'($urandom);
         rm = ref_mux(rs, {7'b0, ra[0]}, {7'b0, rb[0]}, {7'b0, rc[0]}, {7'b0, rd[0]}, {7'b0, re[0]});
         step(rs, {ra[0], rb[0], rc[0], rd[0], re[0]}, rm[0], ra, rb, rc, rd, re,
              $sformatf("rand%0d", i));
      end

      // register path: m changes at once, m_q holds until the next edge
      step(3'b001, 5'b01000, 1'b1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, "regN");
      @(negedge clk);
      {s2, s1, s0} = 3'b000;
      u1 = 1'b0;
      #1;
      check("reg m new", {7'b0, m1}, 8'h00);
      check("reg m_q held", {7'b0, mq1}, 8'h01);
      check("reg sel_q held", {5'b0, selq1}, 8'h01);
      @(posedge clk);
      #1;
      check("reg m_q N+1", {7'b0, mq1}, 8'h00);
      check("reg sel_q N+1", {5'b0, selq1}, 8'h00);

      // async reset between edges
      step(3'b001, 5'b01000, 1'b1, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, "prerst");
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst m_q", {7'b0, mq1}, 8'h00);
      check("arst sel_q", {5'b0, selq1}, 8'h00);
      check("arst m_q8", mq8, 8'h00);
      check("arst m follows", {7'b0, m1}, 8'h01);
      v1 = 1'b0;
      #1;
      check("arst m follows 2", {7'b0, m1}, 8'h00);
      @(posedge clk);
      #1;
      check("arst m_q held low", {7'b0, mq1}, 8'h00);
      @(negedge clk);
      v1 = 1'b1;
      rst_n = 1'b1;
      #5;
      check("release m_q before edge", {7'b0, mq1}, 8'h00);
      @(posedge clk);
      #1;
      check("release m_q reload", {7'b0, mq1}, 8'h01);
      check("release sel_q reload", {5'b0, selq1}, 8'h01);

      // WIDTH=8 patterns
      step(3'b000, 5'b00000, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h3C, "w8 sel000");
      check("w8 const A5", m8, 8'hA5);
      step(3'b111, 5'b00000, 1'b0, 8'hA5, 8'h00, 8'h00, 8'h00, 8'h3C, "w8 sel111");
      check("w8 const 3C", m8, 8'h3C);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
